rs_wakeup_station: RTL and testbench

- Parametrised reservation station for one functional unit.
- Holds up to RS_DEPTH dispatched ops and snoops the common data bus (CDB) to wake up waiting operands.
- Issues the oldest ready op to the FU through a registered valid/ready output stage; supports pipeline flush.
- Sits between dispatch/rename (with ROB tag allocation) and the ALU/FU.

---
 rtl/rs_pkg.sv | 29 ++
 rtl/rs_age_matrix.sv | 38 +++
 rtl/rs_wakeup_station.sv | 140 ++++++++++++++
 tb/tb_rs_wakeup_station.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// rs_pkg: shared widths, opcode encoding and reservation-station entry layout.
package rs_pkg;
  localparam int DATA_W = 32;
  localparam int TAG_W = 3;
  localparam int OP_W = 4;
  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_func_t;
  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   opcode;
    logic [TAG_W-1:0]  rob_idx;
    logic [DATA_W-1:0] v_i;
    logic [DATA_W-1:0] v_j;
    logic [TAG_W-1:0]  q_i;
    logic [TAG_W-1:0]  q_j;
    logic              i_rdy;
    logic              j_rdy;
  } rs_entry_t;
endpackage

// File: rtl/rs_age_matrix.sv
// rs_age_matrix: relative-age tracking; age_q[a][b]=1 means entry a is older than entry b.
module rs_age_matrix #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] alloc_in,
  input  logic [N-1:0] free_in,
  input  logic [N-1:0] elig_in,
  output logic [N-1:0] oldest_out
);
  logic [N-1:0][N-1:0] age_q, age_d;
  // A new entry is younger than everything: its row clears, its column sets.
  always_comb begin
    age_d = age_q;
    for (int i = 0; i < N; i++) begin
      if (free_in[i]) begin
        age_d[i] = '0;
        for (int j = 0; j < N; j++) age_d[j][i] = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (alloc_in[i]) begin
        age_d[i] = '0;
        for (int j = 0; j < N; j++) age_d[j][i] = (j != i);
      end
    end
  end
  always_comb begin
    oldest_out = elig_in;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (j != i && elig_in[j] && age_q[j][i]) oldest_out[i] = 1'b0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) age_q <= '0;
    else age_q <= age_d;
endmodule

// File: rtl/rs_wakeup_station.sv
// rs_wakeup_station: reservation station with CDB wakeup, oldest-first select and a
// registered issue stage feeding one functional unit.
module rs_wakeup_station #(
  parameter int RS_DEPTH = 4,
  parameter int DATA_W = rs_pkg::DATA_W,
  parameter int TAG_W = rs_pkg::TAG_W,
  parameter int OP_W = rs_pkg::OP_W
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        flush_in,
  input  logic                        valid_in,
  output logic                        ready_out,
  input  logic [OP_W-1:0]             opcode_in,
  input  logic [TAG_W-1:0]            rob_idx_in,
  input  logic [DATA_W-1:0]           V_i_in,
  input  logic [DATA_W-1:0]           V_j_in,
  input  logic [TAG_W-1:0]            Q_i_in,
  input  logic [TAG_W-1:0]            Q_j_in,
  input  logic                        i_ready,
  input  logic                        j_ready,
  input  logic                        cdb_valid_in,
  input  logic [TAG_W-1:0]            cdb_tag_in,
  input  logic [DATA_W-1:0]           cdb_data_in,
  input  logic                        fu_ready_in,
  output logic                        issue_valid_out,
  output logic [DATA_W-1:0]           rval1_out,
  output logic [DATA_W-1:0]           rval2_out,
  output logic [OP_W-1:0]             opcode_out,
  output logic [TAG_W-1:0]            rob_idx_out,
  output logic [$clog2(RS_DEPTH):0]   count_out
);
  localparam int IW = $clog2(RS_DEPTH);
  localparam int CW = IW + 1;
  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   opcode;
    logic [TAG_W-1:0]  rob_idx;
    logic [DATA_W-1:0] v_i;
    logic [DATA_W-1:0] v_j;
    logic [TAG_W-1:0]  q_i;
    logic [TAG_W-1:0]  q_j;
    logic              i_rdy;
    logic              j_rdy;
  } entry_t;
  entry_t [RS_DEPTH-1:0] ent_q, ent_d;
  entry_t new_ent;
  logic [RS_DEPTH-1:0] vld, elig, oldest, alloc_oh, free_oh;
  logic [IW-1:0] free_idx, sel_idx;
  logic [CW-1:0] count_q, count_d;
  logic issue_valid_q, issue_valid_d;
  logic [DATA_W-1:0] rval1_q, rval1_d, rval2_q, rval2_d;
  logic [OP_W-1:0] opcode_q, opcode_d;
  logic [TAG_W-1:0] rob_q, rob_d;
  logic disp, load, i_hit, j_hit;
  always_comb begin
    vld = '0;
    elig = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      vld[i] = ent_q[i].valid;
      elig[i] = ent_q[i].valid && ent_q[i].i_rdy && ent_q[i].j_rdy;
    end
  end
  always_comb begin
    free_idx = '0;
    sel_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!vld[i]) free_idx = IW'(i);
      if (oldest[i]) sel_idx = IW'(i);
    end
  end
  assign ready_out = !(&vld);
  assign disp = valid_in && ready_out && !flush_in;
  assign load = (!issue_valid_q || fu_ready_in) && (|elig) && !flush_in;
  assign alloc_oh = disp ? (RS_DEPTH'(1) << free_idx) : '0;
  assign free_oh = load ? oldest : '0;
  // An operand whose producer broadcasts in the dispatch cycle is captured directly.
  assign i_hit = cdb_valid_in && !i_ready && (Q_i_in == cdb_tag_in);
  assign j_hit = cdb_valid_in && !j_ready && (Q_j_in == cdb_tag_in);
  assign new_ent = '{valid: 1'b1, opcode: opcode_in, rob_idx: rob_idx_in,
                     v_i: i_hit ? cdb_data_in : V_i_in, v_j: j_hit ? cdb_data_in : V_j_in,
                     q_i: Q_i_in, q_j: Q_j_in, i_rdy: i_ready || i_hit, j_rdy: j_ready || j_hit};
  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (cdb_valid_in && ent_q[i].valid && !ent_q[i].i_rdy && ent_q[i].q_i == cdb_tag_in) begin
        ent_d[i].i_rdy = 1'b1;
        ent_d[i].v_i = cdb_data_in;
      end
      if (cdb_valid_in && ent_q[i].valid && !ent_q[i].j_rdy && ent_q[i].q_j == cdb_tag_in) begin
        ent_d[i].j_rdy = 1'b1;
        ent_d[i].v_j = cdb_data_in;
      end
      if (free_oh[i]) ent_d[i].valid = 1'b0;
      if (alloc_oh[i]) ent_d[i] = new_ent;
      if (flush_in) ent_d[i].valid = 1'b0;
    end
  end
  always_comb begin
    issue_valid_d = flush_in ? 1'b0 : load ? 1'b1 : fu_ready_in ? 1'b0 : issue_valid_q;
    rval1_d = load ? ent_q[sel_idx].v_i : rval1_q;
    rval2_d = load ? ent_q[sel_idx].v_j : rval2_q;
    opcode_d = load ? ent_q[sel_idx].opcode : opcode_q;
    rob_d = load ? ent_q[sel_idx].rob_idx : rob_q;
    count_d = flush_in ? '0 : count_q + CW'(disp) - CW'(load);
  end
  rs_age_matrix #(.N(RS_DEPTH)) u_age (
    .clk(clk_in),
    .rst(rst_in),
    .alloc_in(alloc_oh),
    .free_in(free_oh),
    .elig_in(elig),
    .oldest_out(oldest)
  );
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ent_q <= '0;
      count_q <= '0;
      issue_valid_q <= 1'b0;
      rval1_q <= '0;
      rval2_q <= '0;
      opcode_q <= '0;
      rob_q <= '0;
    end else begin
      ent_q <= ent_d;
      count_q <= count_d;
      issue_valid_q <= issue_valid_d;
      rval1_q <= rval1_d;
      rval2_q <= rval2_d;
      opcode_q <= opcode_d;
      rob_q <= rob_d;
    end
  end
  assign issue_valid_out = issue_valid_q;
  assign rval1_out = rval1_q;
  assign rval2_out = rval2_q;
  assign opcode_out = opcode_q;
  assign rob_idx_out = rob_q;
  assign count_out = count_q;
endmodule

// File: tb/tb_rs_wakeup_station.sv
// tb_rs_wakeup_station: directed scenarios plus random traffic against an age-ordered queue model.
module tb_rs_wakeup_station;
  localparam int D = 4, DW = 32, TW = 3, OW = 4, CW = $clog2(D) + 1;
  logic clk_in, rst_in, flush_in, valid_in, ready_out;
  logic [OW-1:0] opcode_in, opcode_out;
  logic [TW-1:0] rob_idx_in, Q_i_in, Q_j_in, cdb_tag_in, rob_idx_out;
  logic [DW-1:0] V_i_in, V_j_in, cdb_data_in, rval1_out, rval2_out;
  logic i_ready, j_ready, cdb_valid_in, fu_ready_in, issue_valid_out;
  logic [CW-1:0] count_out;
  typedef struct {
    logic [OW-1:0] op;
    logic [TW-1:0] rob;
    logic [DW-1:0] vi, vj;
    logic [TW-1:0] qi, qj;
    bit ri, rj;
  } ment_t;
  ment_t mq[$];
  bit mo_valid;
  logic [DW-1:0] mo_v1, mo_v2;
  logic [OW-1:0] mo_op;
  logic [TW-1:0] mo_rob;
  int checks, errors;
  rs_wakeup_station #(.RS_DEPTH(D), .DATA_W(DW), .TAG_W(TW), .OP_W(OW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in), .valid_in(valid_in),
    .ready_out(ready_out), .opcode_in(opcode_in), .rob_idx_in(rob_idx_in),
    .V_i_in(V_i_in), .V_j_in(V_j_in), .Q_i_in(Q_i_in), .Q_j_in(Q_j_in),
    .i_ready(i_ready), .j_ready(j_ready), .cdb_valid_in(cdb_valid_in),
    .cdb_tag_in(cdb_tag_in), .cdb_data_in(cdb_data_in), .fu_ready_in(fu_ready_in),
    .issue_valid_out(issue_valid_out), .rval1_out(rval1_out), .rval2_out(rval2_out),
    .opcode_out(opcode_out), .rob_idx_out(rob_idx_out), .count_out(count_out)
  );
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic compare_outputs();
    check("ready_out", ready_out, mq.size() < D);
    check("count_out", count_out, mq.size());
    check("issue_valid", issue_valid_out, mo_valid);
    if (mo_valid) begin
      check("rval1", rval1_out, mo_v1);
      check("rval2", rval2_out, mo_v2);
      check("opcode", opcode_out, mo_op);
      check("rob_idx", rob_idx_out, mo_rob);
    end
  endtask
  // Reference: queue kept in dispatch order, so the oldest eligible op is the first ready one.
  task automatic model_step();
    int k;
    bit load, disp;
    ment_t e;
    k = -1;
    if (flush_in) begin
      mq.delete();
      mo_valid = 0;
      return;
    end
    disp = valid_in && (mq.size() < D);
    foreach (mq[i]) if (k < 0 && mq[i].ri && mq[i].rj) k = i;
    load = (!mo_valid || fu_ready_in) && (k >= 0);
    if (cdb_valid_in) foreach (mq[i]) begin
      if (!mq[i].ri && mq[i].qi == cdb_tag_in) begin mq[i].ri = 1; mq[i].vi = cdb_data_in; end
      if (!mq[i].rj && mq[i].qj == cdb_tag_in) begin mq[i].rj = 1; mq[i].vj = cdb_data_in; end
    end
    if (load) begin
      mo_v1 = mq[k].vi; mo_v2 = mq[k].vj; mo_op = mq[k].op; mo_rob = mq[k].rob;
      mq.delete(k);
      mo_valid = 1;
    end else if (fu_ready_in) mo_valid = 0;
    if (disp) begin
      e.op = opcode_in; e.rob = rob_idx_in; e.qi = Q_i_in; e.qj = Q_j_in;
      e.ri = i_ready || (cdb_valid_in && Q_i_in == cdb_tag_in);
      e.rj = j_ready || (cdb_valid_in && Q_j_in == cdb_tag_in);
      e.vi = i_ready ? V_i_in : cdb_data_in;
      e.vj = j_ready ? V_j_in : cdb_data_in;
      mq.push_back(e);
    end
  endtask
  task automatic step();
    compare_outputs();
    model_step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask
  task automatic clr();
    valid_in = 0; flush_in = 0; cdb_valid_in = 0;
  endtask
  task automatic set_disp(input logic [TW-1:0] rob, input logic [DW-1:0] vi, vj,
                          input logic [TW-1:0] qi, qj, input bit ri, rj);
    valid_in = 1; opcode_in = OW'($urandom); rob_idx_in = rob;
    V_i_in = vi; V_j_in = vj; Q_i_in = qi; Q_j_in = qj; i_ready = ri; j_ready = rj;
  endtask
  initial begin
    checks = 0; errors = 0; mo_valid = 0;
    rst_in = 1; clr(); fu_ready_in = 0;
    opcode_in = 0; rob_idx_in = 0; V_i_in = 0; V_j_in = 0; Q_i_in = 0; Q_j_in = 0;
    i_ready = 0; j_ready = 0; cdb_tag_in = 0; cdb_data_in = 0;
    repeat (2) @(negedge clk_in);
    check("rst_issue_valid", issue_valid_out, 0);
    check("rst_ready", ready_out, 1);
    check("rst_count", count_out, 0);
    check("rst_rval1", rval1_out, 0);
    check("rst_rob", rob_idx_out, 0);
    rst_in = 0;
    fu_ready_in = 1;
    set_disp(3'd2, 5, 7, 0, 0, 1, 1); step(); clr();
    check("lat_t1_valid", issue_valid_out, 0);
    step();
    check("lat_t2_valid", issue_valid_out, 1);
    check("lat_rval1", rval1_out, 5);
    check("lat_rval2", rval2_out, 7);
    check("lat_rob", rob_idx_out, 2);
    step();
    set_disp(3'd1, 0, 9, 3'd4, 0, 0, 1); step();
    set_disp(3'd2, 3, 4, 0, 0, 1, 1); step();
    clr(); cdb_valid_in = 1; cdb_tag_in = 3'd4; cdb_data_in = 'hAA; step();
    check("wake_first_rob", rob_idx_out, 2);
    clr(); step();
    check("wake_second_rob", rob_idx_out, 1);
    check("wake_rval1", rval1_out, 'hAA);
    step(); step();
    fu_ready_in = 0;
    for (int k = 0; k < 5; k++) begin set_disp(TW'(k), DW'(k), DW'(k + 1), 0, 0, 1, 1); step(); end
    check("full_ready", ready_out, 0);
    check("full_count", count_out, 4);
    check("full_held_rob", rob_idx_out, 0);
    set_disp(3'd7, 1, 1, 0, 0, 1, 1); step(); clr();
    check("full_ignored_count", count_out, 4);
    fu_ready_in = 1;
    for (int k = 1; k < 5; k++) begin step(); check("drain_rob", rob_idx_out, k); end
    step();
    set_disp(3'd5, 1, 0, 0, 3'd3, 1, 0);
    cdb_valid_in = 1; cdb_tag_in = 3'd3; cdb_data_in = 'h55; step(); clr(); step();
    check("coll_valid", issue_valid_out, 1);
    check("coll_rval2", rval2_out, 'h55);
    check("coll_rob", rob_idx_out, 5);
    step();
    fu_ready_in = 0;
    for (int k = 0; k < 4; k++) begin set_disp(TW'(k), 1, 2, 0, 0, 1, 1); step(); end
    check("pre_flush_count", count_out, 3);
    check("pre_flush_valid", issue_valid_out, 1);
    set_disp(3'd6, 1, 2, 0, 0, 1, 1); flush_in = 1; step(); clr();
    check("flush_count", count_out, 0);
    check("flush_valid", issue_valid_out, 0);
    check("flush_ready", ready_out, 1);
    step();
    check("flush_no_entry", count_out, 0);
    repeat (3000) begin
      valid_in = ($urandom_range(0, 9) < 6);
      set_disp(TW'($urandom), $urandom, $urandom, TW'($urandom), TW'($urandom),
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      valid_in = ($urandom_range(0, 9) < 6);
      cdb_valid_in = ($urandom_range(0, 9) < 5);
      cdb_tag_in = TW'($urandom);
      cdb_data_in = $urandom;
      fu_ready_in = ($urandom_range(0, 3) != 0);
      flush_in = ($urandom_range(0, 49) == 0);
      step();
    end
    clr(); flush_in = 1; step(); clr();
    fu_ready_in = 0;
    set_disp(3'd3, 8, 9, 0, 0, 1, 1); step(); clr(); step(); step();
    check("pre_reset_valid", issue_valid_out, 1);
    #2 rst_in = 1;
    #1;
    check("async_rst_valid", issue_valid_out, 0);
    check("async_rst_rval1", rval1_out, 0);
    check("async_rst_rval2", rval2_out, 0);
    check("async_rst_opcode", opcode_out, 0);
    check("async_rst_rob", rob_idx_out, 0);
    check("async_rst_ready", ready_out, 1);
    check("async_rst_count", count_out, 0);
    mq.delete(); mo_valid = 0;
    @(negedge clk_in);
    rst_in = 0;
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
